// File: rtl/rename_stage_pkg.sv
// Shared types for the rename/dispatch stage: decoded uop layout, configuration
// record and the per-lane issue bundle produced by rename.
package rename_stage_pkg;

    localparam int unsigned PC_W      = 32;
    localparam int unsigned TAG_W_MAX = 16;

    typedef struct packed {
        int unsigned PLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{PLEN: 32};

    typedef enum logic [2:0] {
        FU_NONE   = 3'd0,
        FU_ALU    = 3'd1,
        FU_MUL    = 3'd2,
        FU_LSU    = 3'd3,
        FU_BRANCH = 3'd4
    } fu_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        fu_e             fu_type;
        logic [4:0]      rd;
        logic            has_rd;
        logic [4:0]      rs1;
        logic            has_rs1;
        logic [4:0]      rs2;
        logic            has_rs2;
        logic            is_store;
    } uop_t;

    // Tags are held at the widest supported size; the stage slices them down.
    typedef struct packed {
        logic                 valid;
        logic                 rs1_in_rob;
        logic [TAG_W_MAX-1:0] rs1_tag;
        logic                 rs2_in_rob;
        logic [TAG_W_MAX-1:0] rs2_tag;
        logic [TAG_W_MAX-1:0] rd_tag;
    } rn_lane_t;

    function automatic int unsigned st_cnt_w(input int unsigned max_stores);
        return (max_stores < 1) ? 1 : $clog2(max_stores + 1);
    endfunction

endpackage

// File: rtl/rename_stage_rat.sv
// Register alias table: per architectural register, whether its newest value is
// still in flight in the ROB and which ROB tag produces it.
module rename_stage_rat
    import rename_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic [2*WIDTH-1:0][4:0]           rd_areg_i,
    output logic [2*WIDTH-1:0]                rd_in_rob_o,
    output logic [2*WIDTH-1:0][TAG_W-1:0]     rd_tag_o,
    input  logic [WIDTH-1:0]                  wr_valid_i,
    input  logic [WIDTH-1:0][4:0]             wr_areg_i,
    input  logic [WIDTH-1:0][TAG_W-1:0]       wr_tag_i,
    input  logic [WIDTH-1:0]                  commit_valid_i,
    input  logic [WIDTH-1:0][4:0]             commit_areg_i,
    input  logic [WIDTH-1:0][TAG_W-1:0]       commit_tag_i
);

    logic [31:0]             busy_q, busy_d;
    logic [31:0][TAG_W-1:0]  tag_q, tag_d;

    always_comb begin
        for (int r = 0; r < 2*WIDTH; r++) begin
            rd_in_rob_o[r] = busy_q[rd_areg_i[r]];
            rd_tag_o[r]    = tag_q[rd_areg_i[r]];
        end
    end

    // A commit only retires the mapping if it is still the newest producer;
    // same-cycle dispatch writes are applied afterwards so they win.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int c = 0; c < WIDTH; c++) begin
            if (commit_valid_i[c] && busy_q[commit_areg_i[c]] &&
                (tag_q[commit_areg_i[c]] == commit_tag_i[c])) begin
                busy_d[commit_areg_i[c]] = 1'b0;
            end
        end
        for (int w = 0; w < WIDTH; w++) begin
            if (wr_valid_i[w] && (wr_areg_i[w] != 5'd0)) begin
                busy_d[wr_areg_i[w]] = 1'b1;
                tag_d[wr_areg_i[w]]  = wr_tag_i[w];
            end
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
        tag_q <= tag_d;
    end

endmodule

// File: rtl/rename_stage.sv
// Rename/dispatch stage: buffers one decode group and each cycle dispatches the
// longest in-order prefix that fits ROB space, SB space and the store limit.
module rename_stage
    import rename_stage_pkg::*;
#(
    parameter cfg_t        Cfg           = EmptyCfg,
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned ROB_DEPTH     = 64,
    parameter int unsigned ROB_IDX_WIDTH = $clog2(ROB_DEPTH),
    parameter int unsigned SB_DEPTH      = 16,
    parameter int unsigned SB_IDX_WIDTH  = $clog2(SB_DEPTH),
    parameter int unsigned MAX_STORES    = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic [WIDTH-1:0]                       dec_valid_i,
    input  uop_t [WIDTH-1:0]                       dec_uops_i,
    output logic                                   dec_ready_o,
    input  logic [ROB_IDX_WIDTH:0]                 rob_free_cnt_i,
    input  logic [ROB_IDX_WIDTH-1:0]               rob_tail_ptr_i,
    output logic [WIDTH-1:0]                       rob_dispatch_valid_o,
    output logic [WIDTH-1:0][Cfg.PLEN-1:0]         rob_dispatch_pc_o,
    output fu_e  [WIDTH-1:0]                       rob_dispatch_fu_type_o,
    output logic [WIDTH-1:0][4:0]                  rob_dispatch_areg_o,
    output logic [WIDTH-1:0]                       rob_dispatch_is_store_o,
    output logic [WIDTH-1:0][SB_IDX_WIDTH-1:0]     rob_dispatch_sb_id_o,
    input  logic [SB_IDX_WIDTH:0]                  sb_free_cnt_i,
    input  logic [SB_IDX_WIDTH-1:0]                sb_alloc_base_i,
    output logic [st_cnt_w(MAX_STORES)-1:0]        sb_alloc_cnt_o,
    output logic [WIDTH-1:0]                       issue_valid_o,
    output logic [WIDTH-1:0]                       issue_rs1_in_rob_o,
    output logic [WIDTH-1:0][ROB_IDX_WIDTH-1:0]    issue_rs1_rob_idx_o,
    output logic [WIDTH-1:0][4:0]                  issue_rs1_idx_o,
    output logic [WIDTH-1:0]                       issue_rs2_in_rob_o,
    output logic [WIDTH-1:0][ROB_IDX_WIDTH-1:0]    issue_rs2_rob_idx_o,
    output logic [WIDTH-1:0][4:0]                  issue_rs2_idx_o,
    output logic [WIDTH-1:0][ROB_IDX_WIDTH-1:0]    issue_rd_rob_idx_o,
    input  logic [WIDTH-1:0]                       commit_valid_i,
    input  logic [WIDTH-1:0][4:0]                  commit_areg_i,
    input  logic [WIDTH-1:0][ROB_IDX_WIDTH-1:0]    commit_rob_idx_i
);

    localparam int unsigned CntW = st_cnt_w(MAX_STORES);
    localparam int unsigned Plen = Cfg.PLEN;
    localparam logic [SB_IDX_WIDTH:0] MaxStores = (SB_IDX_WIDTH+1)'(MAX_STORES);

    logic [WIDTH-1:0]                     buf_vld_q, buf_vld_d;
    uop_t [WIDTH-1:0]                     buf_uop_q, buf_uop_d;

    logic [WIDTH-1:0]                     disp;
    logic [WIDTH-1:0][ROB_IDX_WIDTH-1:0]  lane_rank;
    logic [WIDTH-1:0][SB_IDX_WIDTH-1:0]   lane_srank;
    logic [WIDTH-1:0][ROB_IDX_WIDTH-1:0]  rd_tag;
    logic [SB_IDX_WIDTH:0]                store_cnt;
    logic                                 ready;
    rn_lane_t [WIDTH-1:0]                 lane;

    logic [2*WIDTH-1:0][4:0]              rat_areg;
    logic [2*WIDTH-1:0]                   rat_in_rob;
    logic [2*WIDTH-1:0][ROB_IDX_WIDTH-1:0] rat_tag;
    logic [WIDTH-1:0]                     rat_wr;
    logic [WIDTH-1:0][4:0]                rat_wr_areg;

    // Prefix selection: the first buffered lane that cannot go closes the window.
    always_comb begin
        logic [ROB_IDX_WIDTH:0] rank;
        logic [SB_IDX_WIDTH:0]  srank;
        logic [SB_IDX_WIDTH:0]  st_lim;
        logic                   open;
        rank       = '0;
        srank      = '0;
        open       = !flush_i;
        st_lim     = (sb_free_cnt_i < MaxStores) ? sb_free_cnt_i : MaxStores;
        disp       = '0;
        lane_rank  = '0;
        lane_srank = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lane_rank[i]  = rank[ROB_IDX_WIDTH-1:0];
            lane_srank[i] = srank[SB_IDX_WIDTH-1:0];
            if (buf_vld_q[i]) begin
                if (open && (rank < rob_free_cnt_i) &&
                    (!buf_uop_q[i].is_store || (srank < st_lim))) begin
                    disp[i] = 1'b1;
                    rank    = rank + (ROB_IDX_WIDTH+1)'(1);
                    if (buf_uop_q[i].is_store) begin
                        srank = srank + (SB_IDX_WIDTH+1)'(1);
                    end
                end else begin
                    open = 1'b0;
                end
            end
        end
        store_cnt = srank;
    end

    assign ready       = !flush_i && ((buf_vld_q & ~disp) == '0);
    assign dec_ready_o = ready;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            rd_tag[i]          = rob_tail_ptr_i + lane_rank[i];
            rat_areg[2*i]      = buf_uop_q[i].rs1;
            rat_areg[2*i+1]    = buf_uop_q[i].rs2;
            rat_wr[i]          = disp[i] && buf_uop_q[i].has_rd && (buf_uop_q[i].rd != 5'd0);
            rat_wr_areg[i]     = buf_uop_q[i].rd;
        end
    end

    rename_stage_rat #(
        .WIDTH (WIDTH),
        .TAG_W (ROB_IDX_WIDTH)
    ) u_rat (
        .clk_i          (clk_i),
        .rst_ni         (~rst_i),
        .flush_i        (flush_i),
        .rd_areg_i      (rat_areg),
        .rd_in_rob_o    (rat_in_rob),
        .rd_tag_o       (rat_tag),
        .wr_valid_i     (rat_wr),
        .wr_areg_i      (rat_wr_areg),
        .wr_tag_i       (rd_tag),
        .commit_valid_i (commit_valid_i),
        .commit_areg_i  (commit_areg_i),
        .commit_tag_i   (commit_rob_idx_i)
    );

    // Same-cycle RAW bypass: the youngest older dispatching writer overrides the RAT.
    always_comb begin
        logic                     hit1, hit2;
        logic [ROB_IDX_WIDTH-1:0] t1, t2;
        lane = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        t1   = '0;
        t2   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hit1 = rat_in_rob[2*i];
            t1   = rat_tag[2*i];
            hit2 = rat_in_rob[2*i+1];
            t2   = rat_tag[2*i+1];
            for (int j = 0; j < WIDTH; j++) begin
                if ((j < i) && rat_wr[j]) begin
                    if (buf_uop_q[j].rd == buf_uop_q[i].rs1) begin
                        hit1 = 1'b1;
                        t1   = rd_tag[j];
                    end
                    if (buf_uop_q[j].rd == buf_uop_q[i].rs2) begin
                        hit2 = 1'b1;
                        t2   = rd_tag[j];
                    end
                end
            end
            if (disp[i]) begin
                lane[i].valid      = 1'b1;
                lane[i].rs1_in_rob = buf_uop_q[i].has_rs1 && hit1;
                lane[i].rs1_tag    = buf_uop_q[i].has_rs1 ? TAG_W_MAX'(t1) : '0;
                lane[i].rs2_in_rob = buf_uop_q[i].has_rs2 && hit2;
                lane[i].rs2_tag    = buf_uop_q[i].has_rs2 ? TAG_W_MAX'(t2) : '0;
                lane[i].rd_tag     = TAG_W_MAX'(rd_tag[i]);
            end
        end
    end

    always_comb begin
        sb_alloc_cnt_o = CntW'(store_cnt);
        for (int i = 0; i < WIDTH; i++) begin
            rob_dispatch_valid_o[i]    = lane[i].valid;
            issue_valid_o[i]           = lane[i].valid;
            issue_rs1_in_rob_o[i]      = lane[i].rs1_in_rob;
            issue_rs1_rob_idx_o[i]     = lane[i].rs1_tag[ROB_IDX_WIDTH-1:0];
            issue_rs2_in_rob_o[i]      = lane[i].rs2_in_rob;
            issue_rs2_rob_idx_o[i]     = lane[i].rs2_tag[ROB_IDX_WIDTH-1:0];
            issue_rd_rob_idx_o[i]      = lane[i].rd_tag[ROB_IDX_WIDTH-1:0];
            rob_dispatch_pc_o[i]       = '0;
            rob_dispatch_fu_type_o[i]  = FU_NONE;
            rob_dispatch_areg_o[i]     = '0;
            rob_dispatch_is_store_o[i] = 1'b0;
            rob_dispatch_sb_id_o[i]    = '0;
            issue_rs1_idx_o[i]         = '0;
            issue_rs2_idx_o[i]         = '0;
            if (disp[i]) begin
                rob_dispatch_pc_o[i]       = buf_uop_q[i].pc[Plen-1:0];
                rob_dispatch_fu_type_o[i]  = buf_uop_q[i].fu_type;
                rob_dispatch_areg_o[i]     = buf_uop_q[i].rd;
                rob_dispatch_is_store_o[i] = buf_uop_q[i].is_store;
                rob_dispatch_sb_id_o[i]    = buf_uop_q[i].is_store ?
                                             (sb_alloc_base_i + lane_srank[i]) : '0;
                issue_rs1_idx_o[i]         = buf_uop_q[i].rs1;
                issue_rs2_idx_o[i]         = buf_uop_q[i].rs2;
            end
        end
    end

    always_comb begin
        buf_vld_d = buf_vld_q & ~disp;
        buf_uop_d = buf_uop_q;
        if (flush_i) begin
            buf_vld_d = '0;
        end else if (ready && (|dec_valid_i)) begin
            buf_vld_d = dec_valid_i;
            buf_uop_d = dec_uops_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_vld_q <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
        end
        buf_uop_q <= buf_uop_d;
    end

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: prefix dispatch, tag/SB id allocation,
// RAW bypass, RAT lookup/commit, flush and reset behaviour.
module tb_rename_stage;
    import rename_stage_pkg::*;

    localparam int W = 4, RIW = 6, SIW = 4, CW = 2, PL = 32;

    logic clk = 1'b0;
    logic rst, flush;
    logic [W-1:0] dec_valid;
    uop_t [W-1:0] dec_uops;
    logic dec_ready;
    logic [RIW:0] rob_free;
    logic [RIW-1:0] rob_tail;
    logic [W-1:0] rob_vld, rob_st;
    logic [W-1:0][PL-1:0] rob_pc;
    fu_e [W-1:0] rob_fu;
    logic [W-1:0][4:0] rob_areg;
    logic [W-1:0][SIW-1:0] rob_sbid;
    logic [SIW:0] sb_free;
    logic [SIW-1:0] sb_base;
    logic [CW-1:0] sb_cnt;
    logic [W-1:0] iss_vld, rs1_inrob, rs2_inrob;
    logic [W-1:0][RIW-1:0] rs1_tag, rs2_tag, rd_tag;
    logic [W-1:0][4:0] rs1_idx, rs2_idx;
    logic [W-1:0] cm_vld;
    logic [W-1:0][4:0] cm_areg;
    logic [W-1:0][RIW-1:0] cm_tag;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    rename_stage dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .dec_valid_i(dec_valid), .dec_uops_i(dec_uops), .dec_ready_o(dec_ready),
        .rob_free_cnt_i(rob_free), .rob_tail_ptr_i(rob_tail),
        .rob_dispatch_valid_o(rob_vld), .rob_dispatch_pc_o(rob_pc),
        .rob_dispatch_fu_type_o(rob_fu), .rob_dispatch_areg_o(rob_areg),
        .rob_dispatch_is_store_o(rob_st), .rob_dispatch_sb_id_o(rob_sbid),
        .sb_free_cnt_i(sb_free), .sb_alloc_base_i(sb_base), .sb_alloc_cnt_o(sb_cnt),
        .issue_valid_o(iss_vld),
        .issue_rs1_in_rob_o(rs1_inrob), .issue_rs1_rob_idx_o(rs1_tag), .issue_rs1_idx_o(rs1_idx),
        .issue_rs2_in_rob_o(rs2_inrob), .issue_rs2_rob_idx_o(rs2_tag), .issue_rs2_idx_o(rs2_idx),
        .issue_rd_rob_idx_o(rd_tag),
        .commit_valid_i(cm_vld), .commit_areg_i(cm_areg), .commit_rob_idx_i(cm_tag)
    );

    function automatic uop_t mk(input logic [31:0] pc, input fu_e fu, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic h1,
                                input logic [4:0] rs2, input logic h2, input logic st);
        uop_t u;
        u.pc = pc; u.fu_type = fu; u.rd = rd; u.has_rd = (rd != 5'd0);
        u.rs1 = rs1; u.has_rs1 = h1; u.rs2 = rs2; u.has_rs2 = h2; u.is_store = st;
        return u;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_alu4();
        dec_valid = 4'b1111;
        for (int i = 0; i < W; i++)
            dec_uops[i] = mk(32'h100 + 32'(4*i), FU_ALU, 5'(i+1), 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; dec_valid = '0; dec_uops = '0;
        rob_free = 7'd64; rob_tail = '0; sb_free = 5'd16; sb_base = '0;
        cm_vld = '0; cm_areg = '0; cm_tag = '0;
        cyc(); cyc();
        rst = 1'b0; #1;
        total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", dec_ready); end
        total++; if (iss_vld !== 4'b0000) begin bad++; $display("FAIL rst_iss_vld got=%b exp=0000", iss_vld); end
        total++; if (rob_vld !== 4'b0000) begin bad++; $display("FAIL rst_rob_vld got=%b exp=0000", rob_vld); end
        total++; if (sb_cnt !== 2'd0) begin bad++; $display("FAIL rst_sb_cnt got=%0d exp=0", sb_cnt); end
        total++; if (rd_tag !== '0 || rob_fu[0] !== FU_NONE) begin bad++; $display("FAIL rst_data got=%h/%0d exp=0/0", rd_tag, rob_fu[0]); end
    endtask

    task automatic test_full_group();
        load_alu4(); rob_free = 7'd64; rob_tail = 6'd62; #1;
        total++; if (iss_vld !== 4'b0000) begin bad++; $display("FAIL full_latency got=%b exp=0000", iss_vld); end
        cyc(); dec_valid = '0; #1;
        total++; if (iss_vld !== 4'b1111) begin bad++; $display("FAIL full_vld got=%b exp=1111", iss_vld); end
        total++; if (rd_tag[0] !== 6'd62 || rd_tag[1] !== 6'd63) begin bad++; $display("FAIL full_tag01 got=%0d,%0d exp=62,63", rd_tag[0], rd_tag[1]); end
        total++; if (rd_tag[2] !== 6'd0 || rd_tag[3] !== 6'd1) begin bad++; $display("FAIL full_tag23 got=%0d,%0d exp=0,1", rd_tag[2], rd_tag[3]); end
        total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL full_ready got=%b exp=1", dec_ready); end
        total++; if (rob_pc[3] !== 32'h10c || rob_fu[1] !== FU_ALU || rob_areg[2] !== 5'd3) begin bad++; $display("FAIL full_payload got=%h/%0d/%0d exp=10c/1/3", rob_pc[3], rob_fu[1], rob_areg[2]); end
        cyc(); #1;
        total++; if (iss_vld !== 4'b0000) begin bad++; $display("FAIL full_drained got=%b exp=0000", iss_vld); end
    endtask

    task automatic test_partial();
        load_alu4(); cyc();
        dec_valid = 4'b1111;
        for (int i = 0; i < W; i++) dec_uops[i] = mk(32'h200, FU_MUL, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rob_free = 7'd2; rob_tail = 6'd20; #1;
        total++; if (iss_vld !== 4'b0011) begin bad++; $display("FAIL part_vld1 got=%b exp=0011", iss_vld); end
        total++; if (rd_tag[0] !== 6'd20 || rd_tag[1] !== 6'd21) begin bad++; $display("FAIL part_tag1 got=%0d,%0d exp=20,21", rd_tag[0], rd_tag[1]); end
        total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL part_ready1 got=%b exp=0", dec_ready); end
        cyc(); dec_valid = '0; rob_free = 7'd10; rob_tail = 6'd4; #1;
        total++; if (iss_vld !== 4'b1100) begin bad++; $display("FAIL part_vld2 got=%b exp=1100", iss_vld); end
        total++; if (rd_tag[2] !== 6'd4 || rd_tag[3] !== 6'd5) begin bad++; $display("FAIL part_tag2 got=%0d,%0d exp=4,5", rd_tag[2], rd_tag[3]); end
        total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL part_ready2 got=%b exp=1", dec_ready); end
        total++; if (rob_areg[2] !== 5'd3 || rob_fu[3] !== FU_ALU) begin bad++; $display("FAIL part_kept got=%0d/%0d exp=3/1", rob_areg[2], rob_fu[3]); end
        cyc();
    endtask

    task automatic test_stores();
        dec_valid = 4'b1111;
        for (int i = 0; i < 3; i++) dec_uops[i] = mk(32'h300, FU_LSU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        dec_uops[3] = mk(32'h30c, FU_ALU, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc(); dec_valid = '0; rob_free = 7'd64; rob_tail = 6'd30; sb_free = 5'd16; sb_base = 4'd15; #1;
        total++; if (iss_vld !== 4'b0011 || rob_st !== 4'b0011) begin bad++; $display("FAIL st_vld1 got=%b/%b exp=0011/0011", iss_vld, rob_st); end
        total++; if (rob_sbid[0] !== 4'd15 || rob_sbid[1] !== 4'd0) begin bad++; $display("FAIL st_id1 got=%0d,%0d exp=15,0", rob_sbid[0], rob_sbid[1]); end
        total++; if (sb_cnt !== 2'd2 || dec_ready !== 1'b0) begin bad++; $display("FAIL st_cnt1 got=%0d/%b exp=2/0", sb_cnt, dec_ready); end
        cyc(); sb_base = 4'd1; rob_tail = 6'd32; #1;
        total++; if (iss_vld !== 4'b1100) begin bad++; $display("FAIL st_vld2 got=%b exp=1100", iss_vld); end
        total++; if (rob_sbid[2] !== 4'd1 || rob_sbid[3] !== 4'd0 || sb_cnt !== 2'd1) begin bad++; $display("FAIL st_id2 got=%0d,%0d,%0d exp=1,0,1", rob_sbid[2], rob_sbid[3], sb_cnt); end
        total++; if (rd_tag[2] !== 6'd32 || rd_tag[3] !== 6'd33) begin bad++; $display("FAIL st_tag2 got=%0d,%0d exp=32,33", rd_tag[2], rd_tag[3]); end
        cyc();
    endtask

    task automatic test_bypass_and_rat();
        dec_valid = 4'b1111;
        dec_uops[0] = mk(32'h400, FU_ALU, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        dec_uops[1] = mk(32'h404, FU_ALU, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        dec_uops[2] = mk(32'h408, FU_ALU, 5'd7, 5'd5, 1'b1, 5'd0, 1'b1, 1'b0);
        dec_uops[3] = mk(32'h40c, FU_ALU, 5'd0, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0);
        cyc(); dec_valid = '0; rob_tail = 6'd8; #1;
        total++; if (rs1_inrob[2] !== 1'b1 || rs1_tag[2] !== 6'd9) begin bad++; $display("FAIL byp_l2rs1 got=%b/%0d exp=1/9", rs1_inrob[2], rs1_tag[2]); end
        total++; if (rs2_inrob[2] !== 1'b0 || rs1_idx[2] !== 5'd5 || rs2_idx[2] !== 5'd0) begin bad++; $display("FAIL byp_l2rs2 got=%b/%0d/%0d exp=0/5/0", rs2_inrob[2], rs1_idx[2], rs2_idx[2]); end
        total++; if (rs1_inrob[3] !== 1'b1 || rs1_tag[3] !== 6'd10) begin bad++; $display("FAIL byp_l3rs1 got=%b/%0d exp=1/10", rs1_inrob[3], rs1_tag[3]); end
        total++; if (rs2_inrob[3] !== 1'b1 || rs2_tag[3] !== 6'd9) begin bad++; $display("FAIL byp_l3rs2 got=%b/%0d exp=1/9", rs2_inrob[3], rs2_tag[3]); end
        cyc();
        dec_valid = 4'b0001; dec_uops[0] = mk(32'h500, FU_ALU, 5'd0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
        cyc(); dec_valid = '0; rob_tail = 6'd12; #1;
        total++; if (iss_vld !== 4'b0001 || rs1_inrob[0] !== 1'b1 || rs1_tag[0] !== 6'd9) begin bad++; $display("FAIL rat_rs1 got=%b/%b/%0d exp=0001/1/9", iss_vld, rs1_inrob[0], rs1_tag[0]); end
        total++; if (rs2_inrob[0] !== 1'b1 || rs2_tag[0] !== 6'd10) begin bad++; $display("FAIL rat_rs2 got=%b/%0d exp=1/10", rs2_inrob[0], rs2_tag[0]); end
        cyc();
        cm_vld = 4'b0011; cm_areg[0] = 5'd5; cm_tag[0] = 6'd9; cm_areg[1] = 5'd7; cm_tag[1] = 6'd3;
        dec_valid = 4'b0001;
        cyc(); cm_vld = '0; dec_valid = '0; #1;
        total++; if (rs1_inrob[0] !== 1'b0) begin bad++; $display("FAIL commit_clear got=%b exp=0", rs1_inrob[0]); end
        total++; if (rs2_inrob[0] !== 1'b1 || rs2_tag[0] !== 6'd10) begin bad++; $display("FAIL commit_stale got=%b/%0d exp=1/10", rs2_inrob[0], rs2_tag[0]); end
        cyc();
    endtask

    task automatic test_flush();
        load_alu4(); cyc();
        dec_valid = '0; rob_free = 7'd2; rob_tail = 6'd40; #1;
        total++; if (iss_vld !== 4'b0011) begin bad++; $display("FAIL fl_pre got=%b exp=0011", iss_vld); end
        cyc(); flush = 1'b1; load_alu4(); #1;
        total++; if (iss_vld !== 4'b0000 || sb_cnt !== 2'd0) begin bad++; $display("FAIL fl_vld got=%b/%0d exp=0000/0", iss_vld, sb_cnt); end
        total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%b exp=0", dec_ready); end
        cyc(); flush = 1'b0; rob_free = 7'd64;
        dec_valid = 4'b0001; dec_uops[0] = mk(32'h600, FU_ALU, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0); #1;
        total++; if (iss_vld !== 4'b0000 || dec_ready !== 1'b1) begin bad++; $display("FAIL fl_after got=%b/%b exp=0000/1", iss_vld, dec_ready); end
        cyc(); dec_valid = '0; #1;
        total++; if (iss_vld !== 4'b0001 || rs1_inrob[0] !== 1'b0 || rs1_idx[0] !== 5'd7) begin bad++; $display("FAIL fl_rat got=%b/%b/%0d exp=0001/0/7", iss_vld, rs1_inrob[0], rs1_idx[0]); end
        cyc();
    endtask

    task automatic test_zero_free();
        dec_valid = 4'b0011;
        dec_uops[0] = mk(32'h700, FU_LSU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        dec_uops[1] = mk(32'h704, FU_ALU, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc(); dec_valid = '0; sb_free = 5'd0; sb_base = 4'd3; rob_free = 7'd64; #1;
        total++; if (iss_vld !== 4'b0000 || dec_ready !== 1'b0 || sb_cnt !== 2'd0) begin bad++; $display("FAIL zsb got=%b/%b/%0d exp=0000/0/0", iss_vld, dec_ready, sb_cnt); end
        cyc(); sb_free = 5'd4; rob_free = 7'd0; #1;
        total++; if (iss_vld !== 4'b0000) begin bad++; $display("FAIL zrob got=%b exp=0000", iss_vld); end
        cyc(); rob_free = 7'd64; #1;
        total++; if (iss_vld !== 4'b0011 || rob_sbid[0] !== 4'd3 || sb_cnt !== 2'd1) begin bad++; $display("FAIL zresume got=%b/%0d/%0d exp=0011/3/1", iss_vld, rob_sbid[0], sb_cnt); end
        cyc();
        dec_valid = 4'b1111;
        for (int i = 0; i < W; i++) dec_uops[i] = mk(32'h800, FU_LSU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc(); dec_valid = '0; sb_free = 5'd1; sb_base = 4'd5; #1;
        total++; if (iss_vld !== 4'b0001 || sb_cnt !== 2'd1) begin bad++; $display("FAIL sblim1 got=%b/%0d exp=0001/1", iss_vld, sb_cnt); end
        cyc(); sb_free = 5'd16; sb_base = 4'd6; #1;
        total++; if (iss_vld !== 4'b0110 || rob_sbid[1] !== 4'd6 || rob_sbid[2] !== 4'd7) begin bad++; $display("FAIL sblim2 got=%b/%0d/%0d exp=0110/6/7", iss_vld, rob_sbid[1], rob_sbid[2]); end
        cyc(); sb_base = 4'd8; #1;
        total++; if (iss_vld !== 4'b1000 || rob_sbid[3] !== 4'd8 || rd_tag[3] !== rob_tail) begin bad++; $display("FAIL sblim3 got=%b/%0d/%0d exp=1000/8/%0d", iss_vld, rob_sbid[3], rd_tag[3], rob_tail); end
        cyc();
    endtask

    task automatic test_reset_mid_drain();
        load_alu4(); cyc();
        dec_valid = '0; rob_free = 7'd1; #1;
        total++; if (iss_vld !== 4'b0001) begin bad++; $display("FAIL rmd_pre got=%b exp=0001", iss_vld); end
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; rob_free = 7'd64; #1;
        total++; if (iss_vld !== 4'b0000 || dec_ready !== 1'b1) begin bad++; $display("FAIL rmd_post got=%b/%b exp=0000/1", iss_vld, dec_ready); end
    endtask

    initial begin
        test_reset();
        test_full_group();
        test_partial();
        test_stores();
        test_bypass_and_rat();
        test_flush();
        test_zero_free();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
